bsg_link_reset_sequencer: RTL

Sequences the bring-up and re-bring-up of one bsg_link_sdr/ddr endpoint pair plus its core-side logic (channel tunnel, round-robin concentrator, wide-link adapters). A single Moore FSM drives token, uplink, downlink and downstream resets in the required order, then releases core reset. It replaces host-driven bsg_tag reset toggling with a deterministic, timed sequence in the noc clock domain.

---
 rtl/bsg_link_reset_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bsg_link_reset_sequencer.sv
// Timed reset sequencer for a bsg_link endpoint pair and its core-side logic.
// Optional feature: define BSG_LINK_RESET_SEQ_RETRAIN_EN to add the retrain_i port.
module bsg_link_reset_sequencer #(
    parameter  int wait_cycles_p = 64,
    localparam int cnt_width_lp  = (wait_cycles_p > 1) ? $clog2(wait_cycles_p) : 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
`ifdef BSG_LINK_RESET_SEQ_RETRAIN_EN
    input  logic retrain_i,
`endif
    output logic token_reset_o,
    output logic uplink_reset_o,
    output logic downlink_reset_o,
    output logic downstream_reset_o,
    output logic core_reset_o,
    output logic busy_o,
    output logic done_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOLD       = 3'd1,
        TOKEN      = 3'd2,
        UPLINK     = 3'd3,
        DOWNLINK   = 3'd4,
        DOWNSTREAM = 3'd5,
        DONE       = 3'd6
    } state_e;

    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(wait_cycles_p - 1);

    state_e                  state_r;
    state_e                  state_next_s;
    logic [cnt_width_lp-1:0] cnt_r;
    logic [cnt_width_lp-1:0] cnt_next_s;
    logic                    phase_last_s;
    logic                    restart_s;
    logic [6:0]              outs_s;

    assign phase_last_s = (cnt_r == last_cnt_lp);

    // State and phase counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            cnt_r   <= {cnt_width_lp{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and next-counter decode
    always_comb begin
        state_next_s = state_r;
        restart_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (phase_last_s) begin
                    state_next_s = TOKEN;
                end else begin
                    state_next_s = HOLD;
                end
            end
            TOKEN: begin
                if (phase_last_s) begin
                    state_next_s = UPLINK;
                end else begin
                    state_next_s = TOKEN;
                end
            end
            UPLINK: begin
                if (phase_last_s) begin
                    state_next_s = DOWNLINK;
                end else begin
                    state_next_s = UPLINK;
                end
            end
            DOWNLINK: begin
                if (phase_last_s) begin
                    state_next_s = DOWNSTREAM;
                end else begin
                    state_next_s = DOWNLINK;
                end
            end
            DOWNSTREAM: begin
                if (phase_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DOWNSTREAM;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

`ifdef BSG_LINK_RESET_SEQ_RETRAIN_EN
        // Retrain overrides both phase advance and start, and restarts HOLD timing
        if (retrain_i) begin
            state_next_s = HOLD;
            restart_s    = 1'b1;
        end else begin
            restart_s    = 1'b0;
        end
`endif

        if (restart_s || (state_next_s != state_r)) begin
            cnt_next_s = {cnt_width_lp{1'b0}};
        end else if (busy_o && !phase_last_s) begin
            cnt_next_s = cnt_r + cnt_width_lp'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Output decode from the state register only
    always_comb begin
        outs_s = 7'b0111100;
        case (state_r)
            IDLE:       outs_s = 7'b0111100;
            HOLD:       outs_s = 7'b0111110;
            TOKEN:      outs_s = 7'b1111110;
            UPLINK:     outs_s = 7'b0011110;
            DOWNLINK:   outs_s = 7'b0001110;
            DOWNSTREAM: outs_s = 7'b0000110;
            DONE:       outs_s = 7'b0000001;
            default:    outs_s = 7'b0111100;
        endcase
    end

    assign token_reset_o      = outs_s[6];
    assign uplink_reset_o     = outs_s[5];
    assign downlink_reset_o   = outs_s[4];
    assign downstream_reset_o = outs_s[3];
    assign core_reset_o       = outs_s[2];
    assign busy_o             = outs_s[1];
    assign done_o             = outs_s[0];

endmodule
